bram_port_arbiter: RTL

Sequencer and two-requester arbiter for the single-port order-book block RAM (one access per cycle, registered read data, read-first on write). After reset it zero-fills the whole RAM. It then grants one of two requesters per cycle (order-update path and lookup path) using round-robin, and returns one response per accepted request exactly one cycle later. It sits directly in front of the RAM instance. It is the only driver of the RAM's we/addr/wdata.

---
 rtl/bram_port_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - zero-fill sequencer and round-robin two-port arbiter for a single-port block RAM
module bram_port_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    output logic                  init_done,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_wdata,
    input  logic [DATA_WIDTH-1:0] bram_rdata
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] fill_cnt;
    logic                  last_grant;
    logic                  rsp0_pend;
    logic                  rsp1_pend;
    logic                  running;
    logic                  grant0;
    logic                  grant1;

    // Grant decision: single requester wins outright, contention goes to the one not served last; a clear cycle grants nothing
    always_comb begin
        running = (state == ST_RUN);
        grant0  = running && !clear && req0_valid && (!req1_valid || last_grant);
        grant1  = running && !clear && req1_valid && (!req0_valid || !last_grant);
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign init_done  = running;

    // RAM port mux: fill writes during INIT (suppressed while reset is held), otherwise the granted request
    always_comb begin
        bram_we    = 1'b0;
        bram_addr  = req0_addr;
        bram_wdata = req0_wdata;
        if (state == ST_INIT) begin
            bram_we    = !rst;
            bram_addr  = fill_cnt;
            bram_wdata = '0;
        end else if (grant1) begin
            bram_we    = req1_we;
            bram_addr  = req1_addr;
            bram_wdata = req1_wdata;
        end else if (grant0) begin
            bram_we    = req0_we;
        end
    end

    // Sequencer: walk the fill counter to the last address then run; clear restarts the fill
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_INIT;
            fill_cnt   <= '0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                ST_INIT: begin
                    fill_cnt <= fill_cnt + 1'b1;
                    if (&fill_cnt) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    if (clear) begin
                        state    <= ST_INIT;
                        fill_cnt <= '0;
                    end else if (grant0) begin
                        last_grant <= 1'b0;
                    end else if (grant1) begin
                        last_grant <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Response tracking: the RAM returns data one cycle after the access, so flag which port owns that slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp0_pend <= 1'b0;
            rsp1_pend <= 1'b0;
        end else begin
            rsp0_pend <= grant0;
            rsp1_pend <= grant1;
        end
    end

    assign rsp0_valid = rsp0_pend;
    assign rsp1_valid = rsp1_pend;
    assign rsp0_rdata = bram_rdata;
    assign rsp1_rdata = bram_rdata;

endmodule
